// File: rtl/jk_excite_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jk_excite_driver_if : stream/sync bundle between pattern source, driver     |
// |                       and JK bank.               Revision: 1.0             |
// +----------------------------------------------------------------------------+
interface jk_excite_driver_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             out_valid;
    logic             out_ready;
    logic             sync_req;
    logic [WIDTH-1:0] sync_q;
    logic             sync_ack;
    logic [WIDTH-1:0] model_q;

    modport slave (
        input  in_data, in_valid, out_ready, sync_req, sync_q,
        output in_ready, j, k, out_valid, sync_ack, model_q
    );

    modport master (
        output in_data, in_valid, out_ready, sync_req, sync_q,
        input  in_ready, j, k, out_valid, sync_ack, model_q
    );
endinterface
`default_nettype wire

// File: rtl/jk_excite_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jk_excite_driver : turns target words into J/K excitation for a JK bank,    |
// |                    with target FIFO, shadow model and resync.              |
// | Option macro: JK_TOGGLE_EN (changing bits use J=K=1).  Revision: 1.0       |
// +----------------------------------------------------------------------------+
module jk_excite_driver #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    jk_excite_driver_if.slave   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        SYNC_ACK = 1'b1
    } state_t;

    state_t           state_q;
    logic             sync_ack_q;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] model_q, model_d;
    logic             out_valid_q, out_valid_d;

    logic             w_in_ready;
    logic             w_fifo_empty;
    logic             w_hs;
    logic             w_reg_free;
    logic             w_sync_take;
    logic             w_pop;
    logic             w_push;
    logic [WIDTH-1:0] w_head;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_j_next;
    logic [WIDTH-1:0] w_k_next;

    always_comb begin
        w_in_ready   = rst && (count_q < c_depth);
        w_fifo_empty = (count_q == '0);
        w_hs         = out_valid_q && bus.out_ready;
        w_reg_free   = !out_valid_q || bus.out_ready;
        w_sync_take  = rst && (state_q == RUN) && bus.sync_req && w_reg_free;
        // A taken sync steals the pop slot so the next word sees the synced model.
        w_pop        = w_reg_free && !w_fifo_empty && !w_sync_take;
        w_push       = bus.in_valid && w_in_ready;
        w_head       = mem_q[rd_ptr_q];
        w_base       = w_hs ? tgt_q : model_q;
`ifdef JK_TOGGLE_EN
        w_j_next     = w_base ^ w_head;
        w_k_next     = w_base ^ w_head;
`else
        w_j_next     = ~w_base & w_head;
        w_k_next     = w_base & ~w_head;
`endif
    end

    always_comb begin
        mem_d = mem_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = bus.in_data;
        end
        wr_ptr_d = w_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        j_d         = j_q;
        k_d         = k_q;
        tgt_d       = tgt_q;
        out_valid_d = out_valid_q;
        if (w_pop) begin
            j_d         = w_j_next;
            k_d         = w_k_next;
            tgt_d       = w_head;
            out_valid_d = 1'b1;
        end else if (w_hs) begin
            out_valid_d = 1'b0;
        end

        if (w_sync_take) begin
            model_d = bus.sync_q;
        end else if (w_hs) begin
            model_d = tgt_q;
        end else begin
            model_d = model_q;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            j_q         <= '0;
            k_q         <= '0;
            tgt_q       <= '0;
            model_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            j_q         <= j_d;
            k_q         <= k_d;
            tgt_q       <= tgt_d;
            model_q     <= model_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RUN;
            sync_ack_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (w_sync_take) begin
                        state_q    <= SYNC_ACK;
                        sync_ack_q <= 1'b1;
                    end else begin
                        sync_ack_q <= 1'b0;
                    end
                end
                SYNC_ACK: begin
                    state_q    <= RUN;
                    sync_ack_q <= 1'b0;
                end
                default: begin
                    state_q    <= RUN;
                    sync_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.j         = j_q;
    assign bus.k         = k_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sync_ack  = sync_ack_q;
    assign bus.model_q   = model_q;
endmodule
`default_nettype wire

// File: tb/tb_jk_excite_driver.sv
`default_nettype none
// Bench for jk_excite_driver: directed scenarios with literal expectations,
// then randomized traffic checked each cycle against a queue-based model.
module tb_jk_excite_driver;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    jk_excite_driver_if #(.WIDTH(WIDTH)) bus ();

    jk_excite_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [3:0] mq[$];
    bit         m_valid  = 1'b0;
    bit         m_ack    = 1'b0;
    bit         m_insync = 1'b0;
    logic [3:0] m_tgt    = '0;
    logic [3:0] m_j      = '0;
    logic [3:0] m_k      = '0;
    logic [3:0] m_model  = '0;

    logic [7:0] dut_cons[$];
    int         ack_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] excite(input logic [3:0] cur, input logic [3:0] tgt);
        logic [3:0] jj;
        logic [3:0] kk;
        jj = '0;
        kk = '0;
        for (int i = 0; i < 4; i++) begin
            if (cur[i] != tgt[i]) begin
`ifdef JK_TOGGLE_EN
                jj[i] = 1'b1;
                kk[i] = 1'b1;
`else
                if (tgt[i]) jj[i] = 1'b1;
                else        kk[i] = 1'b1;
`endif
            end
        end
        return {jj, kk};
    endfunction

    always @(posedge clk) begin : model_step
        bit         acc, hs, free, take, pop;
        logic [3:0] base, head, nm;
        logic [7:0] jk;
        if (!rst) begin
            mq.delete();
            m_valid = 0; m_ack = 0; m_insync = 0;
            m_tgt = '0; m_j = '0; m_k = '0; m_model = '0;
        end else begin
            acc  = bus.in_valid && (mq.size() < DEPTH);
            hs   = m_valid && bus.out_ready;
            free = !m_valid || bus.out_ready;
            take = !m_insync && bus.sync_req && free;
            pop  = free && (mq.size() > 0) && !take;
            base = hs ? m_tgt : m_model;
            nm   = take ? bus.sync_q : (hs ? m_tgt : m_model);
            if (pop) begin
                head    = mq.pop_front();
                jk      = excite(base, head);
                m_j     = jk[7:4];
                m_k     = jk[3:0];
                m_tgt   = head;
                m_valid = 1;
            end else if (hs) begin
                m_valid = 0;
            end
            if (acc) mq.push_back(bus.in_data);
            m_model  = nm;
            m_ack    = take;
            m_insync = take;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (rst && (mq.size() < DEPTH))});
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        chk("model_q", {28'd0, bus.model_q}, {28'd0, m_model});
        chk("sync_ack", {31'd0, bus.sync_ack}, {31'd0, m_ack});
        if (m_valid) begin
            chk("j", {28'd0, bus.j}, {28'd0, m_j});
            chk("k", {28'd0, bus.k}, {28'd0, m_k});
        end
        if (rst && bus.out_valid && bus.out_ready) dut_cons.push_back({bus.j, bus.k});
        if (bus.sync_ack === 1'b1) ack_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] t1_words [4];
    logic [7:0] t1_exp   [4];
    logic [3:0] t2_words [5];
    logic [3:0] t5_words [4];
    int         ack_base;
    int         ncons;

    initial begin
        t1_words = '{4'b0000, 4'b1010, 4'b1111, 4'b0101};
`ifdef JK_TOGGLE_EN
        t1_exp   = '{8'h00, 8'hAA, 8'h55, 8'hAA};
`else
        t1_exp   = '{8'h00, 8'hA0, 8'h50, 8'h0A};
`endif
        t2_words = '{4'h3, 4'h6, 4'hC, 4'h9, 4'hE};
        t5_words = '{4'hA, 4'hB, 4'hC, 4'hD};

        rst = 1'b0;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.sync_req = 1'b0; bus.sync_q = '0;
        tick(); tick();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_model_q", {28'd0, bus.model_q}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_sync_ack", {31'd0, bus.sync_ack}, 32'd0);
        rst = 1'b1;

        // Basic stream with out_ready held high
        dut_cons.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = t1_words[i];
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (5) tick();
        chk("t1_count", dut_cons.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < dut_cons.size()) chk("t1_jk", {24'd0, dut_cons[i]}, {24'd0, t1_exp[i]});
        end
        chk("t1_model", {28'd0, bus.model_q}, 32'h5);

        // Fill with consumer stalled, then drain
        dut_cons.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_data = t2_words[i];
            tick();
        end
        bus.in_valid = 1'b0;
        chk("t2_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("t2_staged", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("t2_in_ready_rise", {31'd0, bus.in_ready}, 32'd1);
        repeat (5) tick();
        chk("t2_count", dut_cons.size(), 32'd5);
        chk("t2_model", {28'd0, bus.model_q}, 32'hE);

        // Sync then push
        bus.in_valid = 1'b1; bus.in_data = 4'b0000;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("t3_model0", {28'd0, bus.model_q}, 32'h0);
        ack_base = ack_cnt;
        bus.sync_req = 1'b1; bus.sync_q = 4'b1100;
        tick();
        bus.sync_req = 1'b0;
        chk("t3_ack", {31'd0, bus.sync_ack}, 32'd1);
        chk("t3_model_sync", {28'd0, bus.model_q}, 32'hC);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 4'b1001;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("t3_valid", {31'd0, bus.out_valid}, 32'd1);
`ifdef JK_TOGGLE_EN
        chk("t3_j", {28'd0, bus.j}, 32'h5);
        chk("t3_k", {28'd0, bus.k}, 32'h5);
`else
        chk("t3_j", {28'd0, bus.j}, 32'h1);
        chk("t3_k", {28'd0, bus.k}, 32'h4);
`endif
        tick();
        chk("t3_ack_pulses", ack_cnt - ack_base, 32'd1);

        // Sync while output register is busy
        bus.in_valid = 1'b1; bus.in_data = 4'b0011;
        tick();
        bus.in_valid = 1'b0;
        bus.sync_req = 1'b1; bus.sync_q = 4'b0110;
        tick(); tick();
        chk("t4_model_held", {28'd0, bus.model_q}, 32'hC);
        chk("t4_no_ack", {31'd0, bus.sync_ack}, 32'd0);
        chk("t4_hold_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("t4_model_sync", {28'd0, bus.model_q}, 32'h6);
        chk("t4_no_pop", {31'd0, bus.out_valid}, 32'd0);
        chk("t4_ack", {31'd0, bus.sync_ack}, 32'd1);
        bus.sync_req = 1'b0;
        tick();
        chk("t4_pop_valid", {31'd0, bus.out_valid}, 32'd1);
`ifdef JK_TOGGLE_EN
        chk("t4_j", {28'd0, bus.j}, 32'h5);
        chk("t4_k", {28'd0, bus.k}, 32'h5);
`else
        chk("t4_j", {28'd0, bus.j}, 32'h1);
        chk("t4_k", {28'd0, bus.k}, 32'h4);
`endif
        tick(); tick();

        // Reset mid-stream
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = t5_words[i];
            tick();
        end
        bus.in_valid = 1'b0;
        chk("t5_valid_pre", {31'd0, bus.out_valid}, 32'd1);
        ncons = dut_cons.size();
        rst = 1'b0;
        tick();
        chk("t5_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t5_model", {28'd0, bus.model_q}, 32'h0);
        chk("t5_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("t5_in_ready_rel", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        repeat (4) tick();
        chk("t5_no_stale", {31'd0, bus.out_valid}, 32'd0);
        chk("t5_cons", dut_cons.size(), ncons);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst           = ($urandom_range(0, 63) != 0);
            bus.in_valid  = 1'($urandom);
            bus.in_data   = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.sync_req  = ($urandom_range(0, 7) == 0);
            bus.sync_q    = 4'($urandom);
            tick();
        end
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.sync_req = 1'b0; bus.out_ready = 1'b1;
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
